// File: rtl/stream_upsizer_clearable_cnt.sv
// stream_upsizer_clearable_cnt: wrapping up-counter with synchronous clear taking priority over increment.
module stream_upsizer_clearable_cnt #(
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [Width-1:0] q_o
);
    logic [Width-1:0] q_q, q_d;
    always_comb q_d = clear_i ? '0 : en_i ? q_q + Width'(1) : q_q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) q_q <= '0;
        else q_q <= q_d;
    assign q_o = q_q;
endmodule

// File: rtl/stream_upsizer_clearable.sv
// stream_upsizer_clearable: packs Ratio narrow beats (lane 0 first) into one wide beat;
// clear_i discards partial or held data and counts the discards.
`define SUC_FF(q, d, rv) always_ff @(posedge clk_i or negedge rst_ni) if (!rst_ni) q <= (rv); else q <= (d);
`define SUC_FFLNR(q, d, en) always_ff @(posedge clk_i) if (en) q <= (d);

module stream_upsizer_clearable #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned Ratio     = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic [DataWidth-1:0]         in_data_i,
    input  logic                         in_last_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic [Ratio*DataWidth-1:0]   out_data_o,
    output logic [$clog2(Ratio+1)-1:0]   out_count_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [7:0]                   drop_cnt_o
);
    localparam int unsigned CntW   = $clog2(Ratio);
    localparam int unsigned CountW = $clog2(Ratio+1);

    if (Ratio < 2) begin : g_ratio_check
        $error("stream_upsizer_clearable: Ratio must be >= 2");
    end

    typedef enum logic {FILL, EMIT} state_e;

    state_e                          state_q, state_d;
    logic [CntW-1:0]                 cnt;
    logic [CountW-1:0]               count_q, count_d;
    logic [7:0]                      drop_q, drop_d;
    logic [Ratio-1:0][DataWidth-1:0] data_q;
    logic                            in_hs, out_hs, done, drop_evt;

    // cnt is always 0 while in EMIT, so a beat accepted during EMIT lands in lane 0
    always_comb begin
        in_ready_o  = !clear_i && (state_q == FILL || out_ready_i);
        out_valid_o = !clear_i && state_q == EMIT;
        in_hs       = in_valid_i && in_ready_o;
        out_hs      = out_valid_o && out_ready_i;
        done        = in_hs && (cnt == CntW'(Ratio - 1) || in_last_i);
        drop_evt    = clear_i && (state_q == EMIT || cnt != '0);
        state_d     = clear_i ? FILL : done ? EMIT : out_hs ? FILL : state_q;
        count_d     = clear_i ? '0 : done ? CountW'(cnt) + CountW'(1) : count_q;
        drop_d      = drop_evt && drop_q != 8'hFF ? drop_q + 8'd1 : drop_q;
    end

    stream_upsizer_clearable_cnt #(.Width(CntW)) u_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i || done),
        .en_i    (in_hs),
        .q_o     (cnt)
    );

    `SUC_FF(state_q, state_d, FILL)
    `SUC_FF(count_q, count_d, '0)
    `SUC_FF(drop_q, drop_d, 8'd0)
    `SUC_FFLNR(data_q[cnt], in_data_i, in_hs)

    assign out_data_o  = data_q;
    assign out_count_o = count_q;
    assign drop_cnt_o  = drop_q;
endmodule

`undef SUC_FF
`undef SUC_FFLNR

// File: tb/tb_stream_upsizer_clearable.sv
// tb_stream_upsizer_clearable: directed scenarios plus randomized traffic against a queue-based model.
module tb_stream_upsizer_clearable;
    localparam int DW = 8;
    localparam int R  = 4;
    localparam int CW = $clog2(R + 1);

    logic clk = 0, rst_ni = 0, clear_i = 0;
    logic [DW-1:0] in_data_i = '0;
    logic in_last_i = 0, in_valid_i = 0, out_ready_i = 0;
    logic in_ready_o, out_valid_o;
    logic [R*DW-1:0] out_data_o;
    logic [CW-1:0] out_count_o;
    logic [7:0] drop_cnt_o;

    int total = 0, bad = 0, wide_seen = 0;

    typedef struct {
        logic [R*DW-1:0] data;
        int cnt;
    } wide_t;
    wide_t exp_q[$];
    logic [DW-1:0] part[$];
    int drop_m = 0;

    stream_upsizer_clearable #(.DataWidth(DW), .Ratio(R)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
        .in_data_i(in_data_i), .in_last_i(in_last_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .out_data_o(out_data_o), .out_count_o(out_count_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model: a partial-word list and a queue of whole wide words awaiting output.
    always @(negedge clk) begin
        if (!rst_ni) begin
            exp_q.delete();
            part.delete();
            drop_m = 0;
        end else begin
            automatic logic exp_vld = !clear_i && exp_q.size() != 0;
            automatic logic exp_rdy = !clear_i && (exp_q.size() == 0 || out_ready_i);
            total++;
            if (in_ready_o !== exp_rdy) begin
                bad++;
                $display("FAIL in_ready: got %0b want %0b at %0t", in_ready_o, exp_rdy, $time);
            end
            total++;
            if (out_valid_o !== exp_vld) begin
                bad++;
                $display("FAIL out_valid: got %0b want %0b at %0t", out_valid_o, exp_vld, $time);
            end
            total++;
            if (drop_cnt_o !== 8'(drop_m)) begin
                bad++;
                $display("FAIL drop_cnt: got %0d want %0d at %0t", drop_cnt_o, drop_m, $time);
            end
            if (clear_i) begin
                if (part.size() != 0 || exp_q.size() != 0) drop_m = drop_m < 255 ? drop_m + 1 : 255;
                part.delete();
                exp_q.delete();
            end else begin
                if (exp_vld && out_ready_i) begin
                    automatic wide_t w = exp_q.pop_front();
                    automatic logic mism = 0;
                    for (int i = 0; i < w.cnt; i++)
                        if (out_data_o[i*DW +: DW] !== w.data[i*DW +: DW]) mism = 1;
                    wide_seen++;
                    total++;
                    if (mism || out_count_o !== CW'(w.cnt)) begin
                        bad++;
                        $display("FAIL wide_beat: got data %h count %0d want data %h count %0d at %0t",
                                 out_data_o, out_count_o, w.data, w.cnt, $time);
                    end
                end
                if (in_valid_i && exp_rdy) begin
                    part.push_back(in_data_i);
                    if (part.size() == R || in_last_i) begin
                        automatic wide_t w;
                        w.data = '0;
                        foreach (part[i]) w.data[i*DW +: DW] = part[i];
                        w.cnt = part.size();
                        exp_q.push_back(w);
                        part.delete();
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [DW-1:0] d, input logic last);
        in_valid_i = 1;
        in_data_i  = d;
        in_last_i  = last;
        step();
        in_valid_i = 0;
        in_last_i  = 0;
    endtask

    task automatic test_reset();
        rst_ni = 0;
        repeat (2) step();
        total++;
        if (out_valid_o !== 1'b0 || drop_cnt_o !== 8'd0 || out_count_o !== '0) begin
            bad++;
            $display("FAIL reset_state: got valid %0b drop %0d count %0d want 0 0 0", out_valid_o, drop_cnt_o, out_count_o);
        end
        @(negedge clk);
        #2 rst_ni = 1;
        step();
        total++;
        if (in_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %0b want 1", in_ready_o);
        end
    endtask

    task automatic test_full_word();
        out_ready_i = 1;
        in_valid_i  = 1;
        for (int i = 0; i < 4; i++) begin
            in_data_i = DW'((i + 1) * 8'h11);
            step();
        end
        in_valid_i = 0;
        total++;
        if (out_valid_o !== 1'b1 || out_data_o !== 32'h44332211 || out_count_o !== CW'(4)) begin
            bad++;
            $display("FAIL full_word: got valid %0b data %h count %0d want 1 44332211 4", out_valid_o, out_data_o, out_count_o);
        end
        step();
    endtask

    task automatic test_partial();
        out_ready_i = 1;
        feed(8'hA1, 0);
        feed(8'hA2, 1);
        total++;
        if (out_valid_o !== 1'b1 || out_data_o[15:0] !== 16'hA2A1 || out_count_o !== CW'(2)) begin
            bad++;
            $display("FAIL partial: got valid %0b data %h count %0d want 1 a2a1 2", out_valid_o, out_data_o[15:0], out_count_o);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int w0 = wide_seen;
        out_ready_i = 1;
        in_valid_i  = 1;
        for (int i = 0; i < 16; i++) begin
            in_data_i = DW'($urandom);
            total++;
            if (in_ready_o !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready: got %0b want 1 at beat %0d", in_ready_o, i);
            end
            step();
        end
        in_valid_i = 0;
        step();
        total++;
        if (wide_seen - w0 != 4) begin
            bad++;
            $display("FAIL b2b_count: got %0d wide beats want 4", wide_seen - w0);
        end
    endtask

    task automatic test_hold();
        out_ready_i = 0;
        for (int i = 0; i < 4; i++) feed(DW'(8'hB0 + i), 0);
        in_valid_i = 1;
        in_data_i  = 8'hC0;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (out_data_o !== 32'hB3B2B1B0 || in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin
                bad++;
                $display("FAIL hold: got data %h ready %0b valid %0b want b3b2b1b0 0 1", out_data_o, in_ready_o, out_valid_o);
            end
            step();
        end
        out_ready_i = 1;
        step();
        for (int i = 1; i < 4; i++) begin
            in_data_i = DW'(8'hC0 + i);
            step();
        end
        in_valid_i = 0;
        total++;
        if (out_data_o !== 32'hC3C2C1C0 || out_count_o !== CW'(4)) begin
            bad++;
            $display("FAIL hold_release: got data %h count %0d want c3c2c1c0 4", out_data_o, out_count_o);
        end
        step();
    endtask

    task automatic test_clear();
        out_ready_i = 1;
        feed(8'hD8, 0);
        feed(8'hD9, 0);
        clear_i    = 1;
        in_valid_i = 1;
        in_data_i  = 8'hEE;
        #2;
        total++;
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL clear_gate: got ready %0b valid %0b want 0 0", in_ready_o, out_valid_o);
        end
        step();
        clear_i = 0;
        total++;
        if (drop_cnt_o !== 8'd1 || out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL clear_drop: got drop %0d valid %0b want 1 0", drop_cnt_o, out_valid_o);
        end
        for (int i = 0; i < 4; i++) begin
            in_data_i = DW'(8'hD0 + i);
            step();
        end
        in_valid_i = 0;
        total++;
        if (out_data_o !== 32'hD3D2D1D0 || out_count_o !== CW'(4) || out_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL clear_clean: got data %h count %0d valid %0b want d3d2d1d0 4 1", out_data_o, out_count_o, out_valid_o);
        end
        step();
    endtask

    task automatic test_saturate();
        out_ready_i = 0;
        for (int i = 0; i < 257; i++) begin
            feed(DW'($urandom), 0);
            clear_i = 1;
            step();
            clear_i = 0;
        end
        total++;
        if (drop_cnt_o !== 8'd255) begin
            bad++;
            $display("FAIL saturate: got %0d want 255", drop_cnt_o);
        end
    endtask

    task automatic test_reset_mid_emit();
        out_ready_i = 0;
        for (int i = 0; i < 4; i++) feed(DW'($urandom), 0);
        #2 rst_ni = 0;
        #1;
        total++;
        if (out_valid_o !== 1'b0 || drop_cnt_o !== 8'd0) begin
            bad++;
            $display("FAIL reset_emit: got valid %0b drop %0d want 0 0", out_valid_o, drop_cnt_o);
        end
        @(negedge clk);
        #2 rst_ni = 1;
        step();
        total++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_emit_release: got ready %0b valid %0b want 1 0", in_ready_o, out_valid_o);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            in_valid_i  = $urandom_range(0, 3) != 0;
            in_data_i   = DW'($urandom);
            in_last_i   = $urandom_range(0, 5) == 0;
            out_ready_i = $urandom_range(0, 3) != 0;
            clear_i     = $urandom_range(0, 29) == 0;
            step();
        end
        in_valid_i  = 0;
        in_last_i   = 0;
        clear_i     = 0;
        out_ready_i = 1;
        repeat (3) step();
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial();
        test_back_to_back();
        test_hold();
        test_clear();
        test_saturate();
        test_reset_mid_emit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
